// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats, ALU operation codes.
// DECODE_RV32M_EN widens alu_op by one bit and adds the M-extension codes.
package decode_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   // Eleven base codes plus eight M-ext codes do not fit in four bits.
`ifdef DECODE_RV32M_EN
   localparam int ALU_OP_W = 5;
`else
   localparam int ALU_OP_W = 4;
`endif

   localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_SLL    = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_SLT    = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU   = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SRL    = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SRA    = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(9);
   localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);
`ifdef DECODE_RV32M_EN
   // Ordered by funct3 so MUL + funct3 selects the operation.
   localparam logic [ALU_OP_W-1:0] ALU_MUL    = ALU_OP_W'(16);
   localparam logic [ALU_OP_W-1:0] ALU_MULH   = ALU_OP_W'(17);
   localparam logic [ALU_OP_W-1:0] ALU_MULHSU = ALU_OP_W'(18);
   localparam logic [ALU_OP_W-1:0] ALU_MULHU  = ALU_OP_W'(19);
   localparam logic [ALU_OP_W-1:0] ALU_DIV    = ALU_OP_W'(20);
   localparam logic [ALU_OP_W-1:0] ALU_DIVU   = ALU_OP_W'(21);
   localparam logic [ALU_OP_W-1:0] ALU_REM    = ALU_OP_W'(22);
   localparam logic [ALU_OP_W-1:0] ALU_REMU   = ALU_OP_W'(23);
`endif

   // Register/immediate ALU op for funct7 == 0.
   function automatic logic [ALU_OP_W-1:0] alu_base(input logic [2:0] funct3);
      case (funct3)
         3'd0:    return ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/instruction_decode_imm_gen.sv
// Combinational immediate generator: selects and sign-extends per format.
module imm_gen
   import decode_pkg::*;
(
   input  logic [31:0] instr,
   input  imm_fmt_t    fmt,
   output logic [31:0] imm
);

   logic s;
   assign s = instr[31];

   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{20{s}}, instr[31:20]};
         IMM_S:   imm = {{20{s}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: one-entry pipeline register with valid/ready and flush.
// Define DECODE_RV32M_EN to decode the M extension instead of trapping it.
module instruction_decode
   import decode_pkg::*;
#(
   parameter int instr_size = 32,
   parameter int reg_addr_w = 5,
   parameter int alu_op_w   = ALU_OP_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [instr_size-1:0] in_instr,
   input  logic [instr_size-1:0] in_pc,
   output logic                  in_ready,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [instr_size-1:0] out_pc,
   output logic [reg_addr_w-1:0] rd,
   output logic [reg_addr_w-1:0] rs1,
   output logic [reg_addr_w-1:0] rs2,
   output logic [instr_size-1:0] imm,
   output logic [alu_op_w-1:0]   alu_op,
   output logic                  alu_src_imm,
   output logic                  reg_write,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  branch,
   output logic                  jump,
   output logic                  illegal
);

   state_t state_reg, state_next;
   logic   capture;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   imm_fmt_t              fmt;
   logic [instr_size-1:0] imm_next;
   logic [alu_op_w-1:0]   op_dec, alu_op_next;
   logic src_next, wr_dec, mr_dec, mw_dec, br_dec, jp_dec, ill_next;
   logic reg_write_next, mem_read_next, mem_write_next, branch_next, jump_next;

   imm_gen u_imm_gen (
      .instr (in_instr),
      .fmt   (fmt),
      .imm   (imm_next)
   );

   always_comb begin
      fmt      = IMM_NONE;
      op_dec   = ALU_ADD;
      src_next = 1'b0;
      wr_dec   = 1'b0;
      mr_dec   = 1'b0;
      mw_dec   = 1'b0;
      br_dec   = 1'b0;
      jp_dec   = 1'b0;
      ill_next = 1'b0;
      case (opcode)
         OPC_OP: begin
            wr_dec = 1'b1;
            case (funct7)
               7'b0000000: op_dec = alu_base(funct3);
               7'b0100000: begin
                  if (funct3 == 3'd0)      op_dec = ALU_SUB;
                  else if (funct3 == 3'd5) op_dec = ALU_SRA;
                  else                     ill_next = 1'b1;
               end
`ifdef DECODE_RV32M_EN
               7'b0000001: op_dec = ALU_MUL + ALU_OP_W'(funct3);
`endif
               default: ill_next = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            fmt      = IMM_I;
            src_next = 1'b1;
            wr_dec   = 1'b1;
            op_dec   = alu_base(funct3);
            // Shift-immediates reuse funct7 as an encoding qualifier.
            if (funct3 == 3'd1 && funct7 != 7'b0000000) ill_next = 1'b1;
            if (funct3 == 3'd5) begin
               if (funct7 == 7'b0100000)      op_dec = ALU_SRA;
               else if (funct7 != 7'b0000000) ill_next = 1'b1;
            end
         end
         OPC_LOAD: begin
            fmt      = IMM_I;
            src_next = 1'b1;
            wr_dec   = 1'b1;
            mr_dec   = 1'b1;
            ill_next = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         end
         OPC_STORE: begin
            fmt      = IMM_S;
            src_next = 1'b1;
            mw_dec   = 1'b1;
            ill_next = (funct3 > 3'd2);
         end
         OPC_BRANCH: begin
            fmt      = IMM_B;
            br_dec   = 1'b1;
            ill_next = (funct3 == 3'd2) || (funct3 == 3'd3);
            if (funct3[2:1] == 2'b11)  op_dec = ALU_SLTU;
            else if (funct3[2])        op_dec = ALU_SLT;
            else                       op_dec = ALU_SUB;
         end
         OPC_JAL: begin
            fmt      = IMM_J;
            src_next = 1'b1;
            wr_dec   = 1'b1;
            jp_dec   = 1'b1;
         end
         OPC_JALR: begin
            fmt      = IMM_I;
            src_next = 1'b1;
            wr_dec   = 1'b1;
            jp_dec   = 1'b1;
            ill_next = (funct3 != 3'd0);
         end
         OPC_LUI: begin
            fmt      = IMM_U;
            src_next = 1'b1;
            wr_dec   = 1'b1;
            op_dec   = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            fmt      = IMM_U;
            src_next = 1'b1;
            wr_dec   = 1'b1;
         end
         default: ill_next = 1'b1;
      endcase
   end

   // An illegal encoding must have no architectural side effects downstream.
   assign alu_op_next    = ill_next ? ALU_ADD : op_dec;
   assign reg_write_next = wr_dec && !ill_next && (in_instr[11:7] != 5'd0);
   assign mem_read_next  = mr_dec && !ill_next;
   assign mem_write_next = mw_dec && !ill_next;
   assign branch_next    = br_dec && !ill_next;
   assign jump_next      = jp_dec && !ill_next;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_EMPTY;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = (state_reg == ST_EMPTY) || out_ready;
      capture    = in_valid && in_ready && !flush;
      if (flush)          state_next = ST_EMPTY;
      else if (capture)   state_next = ST_FULL;
      else if (out_ready) state_next = ST_EMPTY;
   end

   assign out_valid = (state_reg == ST_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_pc      <= '0;
         rd          <= '0;
         rs1         <= '0;
         rs2         <= '0;
         imm         <= '0;
         alu_op      <= '0;
         alu_src_imm <= 1'b0;
         reg_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         branch      <= 1'b0;
         jump        <= 1'b0;
         illegal     <= 1'b0;
      end else if (capture) begin
         out_pc      <= in_pc;
         rd          <= in_instr[11:7];
         rs1         <= in_instr[19:15];
         rs2         <= in_instr[24:20];
         imm         <= imm_next;
         alu_op      <= alu_op_next;
         alu_src_imm <= src_next;
         reg_write   <= reg_write_next;
         mem_read    <= mem_read_next;
         mem_write   <= mem_write_next;
         branch      <= branch_next;
         jump        <= jump_next;
         illegal     <= ill_next;
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed plan plus random traffic
// against a behavioural model; honours DECODE_RV32M_EN like the design.
module tb_instruction_decode;
   import decode_pkg::*;

   logic                clk = 1'b0;
   logic                rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0]         in_instr, in_pc, out_pc, imm;
   logic [4:0]          rd, rs1, rs2;
   logic [ALU_OP_W-1:0] alu_op;
   logic alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal;

   instruction_decode dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
      .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]         pc, imm;
      logic [4:0]          rd, rs1, rs2;
      logic [ALU_OP_W-1:0] op;
      logic src, rw, mr, mw, br, jp, ill;
   } exp_t;

   int   n_checks = 0;
   int   n_bad    = 0;
   logic m_valid;
   exp_t m_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t zero_b();
      exp_t e;
      e.pc = 0; e.imm = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.op = ALU_ADD;
      e.src = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.ill = 0;
      return e;
   endfunction

   function automatic logic [ALU_OP_W-1:0] ref_base(input int f3);
      logic [ALU_OP_W-1:0] tbl [8];
      tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      return tbl[f3];
   endfunction

   // Reference decode from the ISA rules, immediates via signed arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      int   f3, f7;
      logic wr;
      logic [31:0] sx;
      e  = zero_b();
      f3 = int'((ins >> 12) & 32'd7);
      f7 = int'(ins >> 25);
      sx = 32'($signed(ins) >>> 31);
      wr = 1'b0;
      e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
      case (ins[6:0])
         OPC_OP: begin
            wr = 1;
            if (f7 == 0) e.op = ref_base(f3);
            else if (f7 == 32 && f3 == 0) e.op = ALU_SUB;
            else if (f7 == 32 && f3 == 5) e.op = ALU_SRA;
`ifdef DECODE_RV32M_EN
            else if (f7 == 1) e.op = ALU_MUL + ALU_OP_W'(f3);
`endif
            else e.ill = 1;
         end
         OPC_OP_IMM: begin
            e.imm = 32'($signed(ins) >>> 20); e.src = 1; wr = 1;
            e.op = ref_base(f3);
            if (f3 == 1 && f7 != 0) e.ill = 1;
            if (f3 == 5 && f7 == 32) e.op = ALU_SRA;
            else if (f3 == 5 && f7 != 0) e.ill = 1;
         end
         OPC_LOAD: begin
            e.imm = 32'($signed(ins) >>> 20); e.src = 1; wr = 1; e.mr = 1;
            e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
         end
         OPC_STORE: begin
            e.imm = (sx << 12) | (((ins >> 25) & 32'h7F) << 5) | ((ins >> 7) & 32'h1F);
            e.src = 1; e.mw = 1; e.ill = (f3 > 2);
         end
         OPC_BRANCH: begin
            e.imm = (sx << 12) | (((ins >> 7) & 32'h1) << 11) |
                    (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            e.br = 1; e.ill = (f3 == 2 || f3 == 3);
            e.op = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
         end
         OPC_JAL: begin
            e.imm = (sx << 20) | (((ins >> 12) & 32'hFF) << 12) |
                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            e.src = 1; wr = 1; e.jp = 1;
         end
         OPC_JALR: begin
            e.imm = 32'($signed(ins) >>> 20); e.src = 1; wr = 1; e.jp = 1; e.ill = (f3 != 0);
         end
         OPC_LUI:   begin e.imm = ins & 32'hFFFFF000; e.src = 1; wr = 1; e.op = ALU_PASS_B; end
         OPC_AUIPC: begin e.imm = ins & 32'hFFFFF000; e.src = 1; wr = 1; end
         default:   e.ill = 1;
      endcase
      if (e.ill) begin
         e.op = ALU_ADD; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
      end
      e.rw = wr && !e.ill && (e.rd != 0);
      return e;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".pc"},    out_pc, m_b.pc);
      chk({tag, ".rd"},    32'(rd),  32'(m_b.rd));
      chk({tag, ".rs1"},   32'(rs1), 32'(m_b.rs1));
      chk({tag, ".rs2"},   32'(rs2), 32'(m_b.rs2));
      chk({tag, ".imm"},   imm, m_b.imm);
      chk({tag, ".op"},    32'(alu_op), 32'(m_b.op));
      chk({tag, ".flags"}, {25'd0, alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal},
          {25'd0, m_b.src, m_b.rw, m_b.mr, m_b.mw, m_b.br, m_b.jp, m_b.ill});
   endtask

   // One clock: drive at negedge, check in_ready, advance model at posedge, check at next negedge.
   task automatic step(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy, input logic fl, input logic rs);
      logic rdy_exp;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
      #1;
      rdy_exp = !m_valid || ordy;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy_exp));
      @(posedge clk);
      if (rs) begin
         m_valid = 0; m_b = zero_b();
      end else if (fl) begin
         m_valid = 0;
      end else if (v && rdy_exp) begin
         m_valid = 1; m_b = ref_decode(ins, pc);
         $display("xact %s pc=%h instr=%h", tag, pc, ins);
      end else if (ordy) begin
         m_valid = 0;
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   logic [6:0] opc_tbl [10];
   logic [6:0] f7_tbl  [4];

   initial begin
      opc_tbl = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
                  OPC_JALR, OPC_LUI, OPC_AUIPC, 7'b1111111};
      f7_tbl  = '{7'h00, 7'h20, 7'h01, 7'h55};
      m_valid = 0; m_b = zero_b();
      rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0;
      @(negedge clk);
      step("reset", 1, 32'h00500093, 32'h40, 1, 0, 1);
      chk("reset.in_ready", 32'(in_ready), 1);
      chk("reset.valid", 32'(out_valid), 0);

      step("addi", 1, 32'h00500093, 32'h0, 1, 0, 0);
      chk("addi.rd", 32'(rd), 1); chk("addi.imm", imm, 5);
      chk("addi.src", 32'(alu_src_imm), 1); chk("addi.rw", 32'(reg_write), 1);

      step("sw", 1, 32'hFE20AE23, 32'h4, 1, 0, 0);
      chk("sw.rs1", 32'(rs1), 1); chk("sw.rs2", 32'(rs2), 2);
      chk("sw.imm", imm, 32'hFFFFFFFC); chk("sw.mw", 32'(mem_write), 1);
      chk("sw.rw", 32'(reg_write), 0);

      step("jal", 1, 32'h008000EF, 32'h100, 1, 0, 0);
      chk("jal.jump", 32'(jump), 1); chk("jal.imm", imm, 8); chk("jal.pc", out_pc, 32'h100);

      for (int i = 0; i < 3; i++) step("stall", 1, 32'h00A00113, 32'h104, 0, 0, 0);
      chk("stall.in_ready", 32'(in_ready), 0);
      chk("stall.pc", out_pc, 32'h100);
      step("resume", 1, 32'h00A00113, 32'h104, 1, 0, 0);
      chk("resume.pc", out_pc, 32'h104); chk("resume.imm", imm, 10);

      step("flush", 1, 32'h00300193, 32'h200, 0, 1, 0);
      chk("flush.valid", 32'(out_valid), 0); chk("flush.pc", out_pc, 32'h104);

      step("allones", 1, 32'hFFFFFFFF, 32'h300, 1, 0, 0);
      chk("allones.ill", 32'(illegal), 1); chk("allones.rw", 32'(reg_write), 0);

      step("mul", 1, 32'h022081B3, 32'h304, 1, 0, 0);
`ifdef DECODE_RV32M_EN
      chk("mul.op", 32'(alu_op), 32'(ALU_MUL)); chk("mul.rd", 32'(rd), 3);
      chk("mul.rw", 32'(reg_write), 1);
`else
      chk("mul.ill", 32'(illegal), 1); chk("mul.rw", 32'(reg_write), 0);
`endif

      step("midrst", 1, 32'h00500093, 32'h308, 0, 0, 0);
      step("midrst", 1, 32'h00500093, 32'h30C, 0, 0, 1);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] r, ins;
         r   = $urandom;
         ins = {f7_tbl[$urandom_range(0, 3)], r[24:7], opc_tbl[$urandom_range(0, 9)]};
         if ($urandom_range(0, 9) == 0) ins = $urandom;
         step("rand", ($urandom_range(0, 9) < 7), ins, $urandom,
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 49) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Stage directly downstream of instruction_fetch in the RV32I CPU.
- Takes the 32-bit fetched instruction plus its PC and produces registered fields: register indices, sign-extended immediate, ALU op, and control flags.
- Holds one decoded instruction in a pipeline register with a valid/ready handshake on both sides.
- Supports a flush input, driven by the branch/jump resolution stage, that kills the held instruction.

Parameters:
- instr_size, 32, instruction and PC width (fixed 32 for RISC-V).
- reg_addr_w, 5, register index width.
- alu_op_w, 4, width of encoded ALU operation.

Ports:
- clk  in  1  global clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a valid instruction.
- in_instr  in  instr_size  raw instruction from fetch.
- in_pc  in  instr_size  PC of in_instr.
- in_ready  out  1  decode can accept (combinational).
- flush  in  1  discard held instruction and any same-cycle capture.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  instr_size  PC of the decoded instruction.
- rd, rs1, rs2  out  reg_addr_w each  register indices.
- imm  out  instr_size  sign-extended immediate (0 for R-type).
- alu_op  out  alu_op_w  ALU operation code from decode_pkg.
- alu_src_imm  out  1  ALU operand B is imm.
- reg_write  out  1  instruction writes rd (0 when rd==0).
- mem_read, mem_write  out  1 each  load / store.
- branch, jump  out  1 each  conditional branch / JAL or JALR.
- illegal  out  1  unsupported encoding.

Behaviour:
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready.
- Capture when in_valid && in_ready && !flush. Decoded fields are registered and appear on the next edge (latency 1). State goes to or stays FULL.
- FULL with out_ready=1 and no capture: go to EMPTY.
- FULL with out_ready=0: every output holds its value exactly.
- flush has priority over everything: next state EMPTY, out_valid=0, other outputs unchanged. A capture in the same cycle is dropped.
- rst has priority over flush: all outputs 0, state EMPTY, so in_ready=1 one cycle after rst. Reset in the middle of an operation discards the held bundle.
- Immediate formats, all sign-extended from bit 31:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Supported opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Any other opcode, or a bad funct3/funct7 in a supported opcode, sets illegal=1.
- When illegal=1: reg_write, mem_read, mem_write, branch and jump are all forced to 0, and out_valid still asserts so the downstream stage can trap.
- rs1/rs2 are decoded from fixed bit positions regardless of format. Consumers qualify them with the control flags.

Optional Feature:
- DECODE_RV32M_EN defined: OP with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to the M-ext alu_op codes in decode_pkg, with reg_write=1.
- Not defined: those encodings set illegal=1.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - imm format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE);
  - alu_op codes, including the M-ext codes.
- One sub-module, imm_gen: purely combinational, takes instr and format, returns the 32-bit immediate.

Test Plan:
- After rst, drive 0x00500093 (addi x1,x0,5) with in_valid=1, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_src_imm=1, reg_write=1, illegal=0.
- Drive 0xFE20AE23 (sw x2,-4(x1)) -> rs1=1, rs2=2, imm=0xFFFFFFFC, mem_write=1, reg_write=0.
- Drive 0x008000EF (jal x1,+8) with in_pc=0x100 -> jump=1, rd=1, imm=8, out_pc=0x100.
- Backpressure: hold out_ready=0 for 3 cycles while FULL -> in_ready=0, all outputs stable. Then out_ready=1 -> next instruction captured the following cycle.
- Flush: assert flush together with in_valid while FULL -> next cycle out_valid=0 and the offered instruction is not captured.
- Drive 0xFFFFFFFF -> illegal=1, all write/mem/branch flags 0. Drive 0x022081B3 (mul x3,x1,x2) -> illegal=1 without DECODE_RV32M_EN; with the macro, the MUL alu_op, rd=3 and reg_write=1.
